wrr_arbiter: RTL and testbench

Weighted round-robin arbiter with per-port burst credits. It grants one of PORTS requesters and holds the grant for up to `weight[i]` acknowledged transfers, then rotates to the next requester. Rotation is back-to-back, with no idle cycle between grants. It sits in front of shared-resource muxes (AXI/AXI-stream crossbars, memory ports) wherever plain round-robin starves bursty masters or splits their bursts.

---
 rtl/wrr_arbiter.sv | 141 ++++++++++++++
 tb/tb_wrr_arbiter.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/wrr_arbiter.sv
// Weighted round-robin arbiter: holds each grant for up to weight[i] acknowledged transfers.
// Define WRR_ARBITER_URGENT_EN to add the urgent-class candidate filter.
module wrr_arbiter #(
  parameter int unsigned PORTS             = 4,
  parameter int unsigned WEIGHT_W          = 4,
  parameter bit          LSB_HIGH_PRIORITY = 1'b1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [PORTS-1:0]            request,
  input  logic [PORTS-1:0]            acknowledge,
  input  logic [PORTS*WEIGHT_W-1:0]   weight,
`ifdef WRR_ARBITER_URGENT_EN
  input  logic [PORTS-1:0]            urgent,
`endif
  output logic [PORTS-1:0]            grant,
  output logic                        grant_valid,
  output logic [$clog2(PORTS)-1:0]    grant_encoded,
  output logic [WEIGHT_W-1:0]         credit
);

  localparam int unsigned IdxW = $clog2(PORTS);
  // Pointer reset so the first search lands on the highest-priority port.
  localparam logic [IdxW-1:0] PtrReset = LSB_HIGH_PRIORITY ? IdxW'(PORTS - 1) : '0;

  typedef enum logic [0:0] {StIdle = 1'b0, StGrant = 1'b1} state_e;

  state_e              state_q, state_d;
  logic [PORTS-1:0]    grant_q, grant_d;
  logic [IdxW-1:0]     enc_q, enc_d;
  logic [IdxW-1:0]     ptr_q, ptr_d;
  logic [WEIGHT_W-1:0] credit_q, credit_d;

  logic [WEIGHT_W-1:0] weight_arr [PORTS];
  logic [PORTS-1:0]    cand;
  logic [IdxW-1:0]     win_idx;
  logic [WEIGHT_W-1:0] load_credit;
  logic                found;
  logic                decide;
  logic                cur_req;
  logic                cur_ack;

  always_comb begin
    for (int unsigned i = 0; i < PORTS; i++) begin
      weight_arr[i] = weight[i*WEIGHT_W +: WEIGHT_W];
    end
  end

`ifdef WRR_ARBITER_URGENT_EN
  assign cand = (|(request & urgent)) ? (request & urgent) : request;
`else
  assign cand = request;
`endif

  // Rotating search starting one past the last winner.
  always_comb begin
    int unsigned idx;
    idx     = 0;
    found   = 1'b0;
    win_idx = '0;
    for (int unsigned k = 1; k <= PORTS; k++) begin
      idx = LSB_HIGH_PRIORITY ? (32'(ptr_q) + k) : (32'(ptr_q) + PORTS - k);
      if (idx >= PORTS) begin
        idx = idx - PORTS;
      end
      if (!found && cand[IdxW'(idx)]) begin
        found   = 1'b1;
        win_idx = IdxW'(idx);
      end
    end
  end

  assign load_credit = (weight_arr[win_idx] == '0) ? WEIGHT_W'(1) : weight_arr[win_idx];

  // FSM next state.
  always_comb begin
    cur_req = request[enc_q];
    cur_ack = acknowledge[enc_q];
    decide  = (state_q == StIdle) ||
              (cur_ack && (credit_q == WEIGHT_W'(1))) ||
              (!cur_req && !cur_ack);
    state_d = state_q;
    if (decide) begin
      state_d = found ? StGrant : StIdle;
    end
  end

  // Grant, pointer and credit next state.
  always_comb begin
    grant_d  = grant_q;
    enc_d    = enc_q;
    ptr_d    = ptr_q;
    credit_d = credit_q;
    if (decide) begin
      if (found) begin
        grant_d          = '0;
        grant_d[win_idx] = 1'b1;
        enc_d            = win_idx;
        ptr_d            = win_idx;
        credit_d         = load_credit;
      end else begin
        grant_d  = '0;
        enc_d    = '0;
        credit_d = '0;
      end
    end else if (cur_ack) begin
      // Non-decision ack implies credit_q > 1, so this cannot underflow.
      credit_d = credit_q - WEIGHT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      grant_q  <= '0;
      enc_q    <= '0;
      ptr_q    <= PtrReset;
      credit_q <= '0;
    end else begin
      grant_q  <= grant_d;
      enc_q    <= enc_d;
      ptr_q    <= ptr_d;
      credit_q <= credit_d;
    end
  end

  always_comb begin
    grant         = grant_q;
    grant_valid   = (state_q == StGrant);
    grant_encoded = enc_q;
    credit        = credit_q;
  end

endmodule

// File: tb/tb_wrr_arbiter.sv
// Self-checking bench for wrr_arbiter: directed scenarios plus randomized traffic
// compared every cycle against a burst-level reference model.
module tb_wrr_arbiter;

  localparam int P   = 4;
  localparam int WW  = 4;
  localparam bit LSB = 1'b1;

  logic               clk;
  logic               rst;
  logic [P-1:0]       request;
  logic [P-1:0]       acknowledge;
  logic [P*WW-1:0]    weight;
`ifdef WRR_ARBITER_URGENT_EN
  logic [P-1:0]       urgent;
`endif
  logic [P-1:0]       grant;
  logic               grant_valid;
  logic [$clog2(P)-1:0] grant_encoded;
  logic [WW-1:0]      credit;

  int n_checks;
  int n_fail;

  // Reference model state: holder index (-1 when idle), remaining credit, last winner.
  int m_hold;
  int m_credit;
  int m_last;

  wrr_arbiter #(
    .PORTS             (P),
    .WEIGHT_W          (WW),
    .LSB_HIGH_PRIORITY (LSB)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .request       (request),
    .acknowledge   (acknowledge),
    .weight        (weight),
`ifdef WRR_ARBITER_URGENT_EN
    .urgent        (urgent),
`endif
    .grant         (grant),
    .grant_valid   (grant_valid),
    .grant_encoded (grant_encoded),
    .credit        (credit)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_hold   = -1;
    m_credit = 0;
    m_last   = LSB ? P - 1 : 0;
  endtask

  task automatic model_step();
    logic [P-1:0] cand;
    bit           decide;
    int           win;
    int           idx;
    int           wt;
    if (m_hold < 0) decide = 1'b1;
    else if (acknowledge[m_hold] && m_credit == 1) decide = 1'b1;
    else if (!request[m_hold] && !acknowledge[m_hold]) decide = 1'b1;
    else decide = 1'b0;

    if (decide) begin
      cand = request;
`ifdef WRR_ARBITER_URGENT_EN
      if ((request & urgent) != '0) cand = request & urgent;
`endif
      win = -1;
      for (int k = 1; k <= P; k++) begin
        idx = (((m_last + (LSB ? k : -k)) % P) + P) % P;
        if (win < 0 && cand[idx]) win = idx;
      end
      if (win < 0) begin
        m_hold   = -1;
        m_credit = 0;
      end else begin
        wt       = int'(weight[win*WW +: WW]);
        m_hold   = win;
        m_last   = win;
        m_credit = (wt == 0) ? 1 : wt;
      end
    end else if (acknowledge[m_hold]) begin
      m_credit = m_credit - 1;
    end
  endtask

  // Advance one clock, update the model with the inputs seen at the edge, compare.
  task automatic step();
    if (rst) model_reset();
    else model_step();
    @(posedge clk);
    #1;
    check_eq("grant", int'(grant), (m_hold < 0) ? 0 : (1 << m_hold));
    check_eq("grant_valid", int'(grant_valid), (m_hold < 0) ? 0 : 1);
    check_eq("grant_encoded", int'(grant_encoded), (m_hold < 0) ? 0 : m_hold);
    check_eq("credit", int'(credit), m_credit);
  endtask

  task automatic set_weights(input int v);
    for (int i = 0; i < P; i++) weight[i*WW +: WW] = WW'(v);
  endtask

  task automatic do_reset();
    rst         = 1'b1;
    request     = '0;
    acknowledge = '0;
`ifdef WRR_ARBITER_URGENT_EN
    urgent      = '0;
`endif
    step();
    step();
    rst = 1'b0;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    model_reset();
    rst         = 1'b1;
    request     = '0;
    acknowledge = '0;
    weight      = '0;
`ifdef WRR_ARBITER_URGENT_EN
    urgent      = '0;
`endif

    // Reset held with all requests asserted.
    request = 4'b1111;
    set_weights(2);
    step();
    step();
    check_eq("rst_grant", int'(grant), 0);
    check_eq("rst_credit", int'(credit), 0);
    rst = 1'b0;
    step();
    check_eq("first_grant", int'(grant), 1);

    // Single requester re-granted back to back.
    do_reset();
    set_weights(1);
    weight[0 +: WW] = 4'd3;
    request     = 4'b0001;
    acknowledge = 4'b1111;
    begin
      int exp_cr[6] = '{3, 2, 1, 3, 2, 1};
      for (int i = 0; i < 6; i++) begin
        step();
        check_eq("solo_credit", int'(credit), exp_cr[i]);
        check_eq("solo_valid", int'(grant_valid), 1);
      end
    end

    // Full contention, weight 2.
    do_reset();
    set_weights(2);
    request     = 4'b1111;
    acknowledge = 4'b1111;
    begin
      int exp_enc[9] = '{0, 0, 1, 1, 2, 2, 3, 3, 0};
      for (int i = 0; i < 9; i++) begin
        step();
        check_eq("rr_enc", int'(grant_encoded), exp_enc[i]);
      end
    end

    // Zero weights behave as one.
    do_reset();
    set_weights(0);
    request     = 4'b1010;
    acknowledge = 4'b1111;
    for (int i = 0; i < 4; i++) begin
      step();
      check_eq("w0_enc", int'(grant_encoded), (i % 2 == 0) ? 1 : 3);
    end

    // Holder drops request without ack, then everyone drops.
    do_reset();
    set_weights(4);
    request     = 4'b0010;
    acknowledge = 4'b0000;
    step();
    check_eq("drop_hold", int'(grant_encoded), 1);
    request = 4'b0101;
    step();
    check_eq("drop_next", int'(grant_encoded), 2);
    request = 4'b0000;
    step();
    check_eq("drop_valid", int'(grant_valid), 0);
    check_eq("drop_credit", int'(credit), 0);

`ifdef WRR_ARBITER_URGENT_EN
    // Urgent class wins every decision; rotation resumes after it clears.
    do_reset();
    set_weights(1);
    request     = 4'b1111;
    acknowledge = 4'b1111;
    urgent      = 4'b1000;
    for (int i = 0; i < 4; i++) begin
      step();
      check_eq("urg_enc", int'(grant_encoded), 3);
    end
    urgent = 4'b0000;
    step();
    check_eq("urg_resume", int'(grant_encoded), 0);
`endif

    // Randomized traffic against the model.
    do_reset();
    for (int i = 0; i < 600; i++) begin
      rst = ($urandom_range(0, 59) == 0);
      if ($urandom_range(0, 3) == 0) request = P'($urandom);
      acknowledge = P'($urandom);
      if ($urandom_range(0, 7) == 0) weight = (P*WW)'($urandom);
`ifdef WRR_ARBITER_URGENT_EN
      if ($urandom_range(0, 5) == 0) urgent = ($urandom_range(0, 1) == 0) ? '0 : P'($urandom);
`endif
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
